// File: rtl/tournament_pred_pkg.sv
// Shared constants, counter helpers and metadata layout
// for the parametrised tournament branch predictor.
package tournament_pred_pkg;

    localparam logic [1:0] CTR_WEAK_TAKEN = 2'b10;
    localparam logic [1:0] CTR_WEAK_LOCAL = 2'b01;
    localparam logic [1:0] CTR_MAX        = 2'b11;
    localparam logic [1:0] CTR_MIN        = 2'b00;

    // pred_meta = {ghist, local_pred, global_pred, final_pred}
    localparam int META_FINAL  = 0;
    localparam int META_GLOBAL = 1;
    localparam int META_LOCAL  = 2;
    localparam int META_GHIST  = 3;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_INC,
        CMD_DEC,
        CMD_INIT
    } ctr_cmd_t;

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == CTR_MAX) ? v : v + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec2(input logic [1:0] v);
        return (v == CTR_MIN) ? v : v - 2'd1;
    endfunction

endpackage

// File: rtl/sat_counter_table.sv
// Table of 2-bit saturating counters: async read,
// one synchronous write port taking inc/dec/init commands.
module sat_counter_table
    import tournament_pred_pkg::*;
#(
    parameter int         IDX_BITS = 4,
    parameter logic [1:0] INIT_VAL = CTR_WEAK_TAKEN
) (
    input  logic                clk,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic [1:0]          rd_val,
    input  logic [1:0]          wr_cmd,
    input  logic [IDX_BITS-1:0] wr_idx
);

    logic [1:0] mem [2**IDX_BITS];

    assign rd_val = mem[rd_idx];

    always_ff @(posedge clk) begin
        case (wr_cmd)
            CMD_INC:  mem[wr_idx] <= sat_inc2(mem[wr_idx]);
            CMD_DEC:  mem[wr_idx] <= sat_dec2(mem[wr_idx]);
            CMD_INIT: mem[wr_idx] <= INIT_VAL;
            default:  ;
        endcase
    end

endmodule

// File: rtl/tournament_predictor_param.sv
// Tournament predictor: local + gshare tables with a per-PC
// chooser, table-init FSM, update metadata and perf counters.
module tournament_predictor_param
    import tournament_pred_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int LOCAL_IDX_BITS = 4,
    parameter int GHIST_BITS     = 8,
    parameter int PC_SHIFT       = 0,
    parameter int GSHARE         = 1,
    parameter int PERF_W         = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  predict_valid,
    input  logic [ADDR_W-1:0]     pc_branch_addr,
    input  logic [ADDR_W-1:0]     offset,
    output logic [ADDR_W-1:0]     out_branch_addr,
    output logic                  prediction,
    output logic [GHIST_BITS+2:0] pred_meta,
    input  logic                  update_valid,
    input  logic [ADDR_W-1:0]     update_pc,
    input  logic [GHIST_BITS+2:0] update_meta,
    input  logic                  actual_taken,
    output logic                  ready,
    output logic [PERF_W-1:0]     perf_branches,
    output logic [PERF_W-1:0]     perf_mispredicts
);

    localparam int IDX_W = (LOCAL_IDX_BITS > GHIST_BITS)
                         ? LOCAL_IDX_BITS : GHIST_BITS;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        init_idx_q;
    logic [GHIST_BITS-1:0]   ghist_q;
    logic [PERF_W-1:0]       perf_b_q, perf_m_q;
    logic                    init_we, upd_en;

    function automatic logic [LOCAL_IDX_BITS-1:0] lidx_of(
        input logic [ADDR_W-1:0] pc
    );
        return pc[PC_SHIFT +: LOCAL_IDX_BITS];
    endfunction

    function automatic logic [GHIST_BITS-1:0] gidx_of(
        input logic [ADDR_W-1:0]     pc,
        input logic [GHIST_BITS-1:0] hist
    );
        if (GSHARE != 0)
            return hist ^ pc[PC_SHIFT +: GHIST_BITS];
        return hist;
    endfunction

    // FSM: state register / next state / outputs
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_INIT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (&init_idx_q) state_d = ST_RUN;
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        ready   = (state_q == ST_RUN);
        init_we = (state_q == ST_INIT) & ~reset;
    end

    assign upd_en = update_valid & ready & ~reset;

    // Predict path
    logic [1:0] local_rd, global_rd, chooser_rd;
    logic       local_pred, global_pred, final_pred;

    assign local_pred  = local_rd[1];
    assign global_pred = global_rd[1];
    assign final_pred  = chooser_rd[1] ? global_pred : local_pred;

    assign prediction      = final_pred & predict_valid & ready;
    assign pred_meta       = {ghist_q, local_pred, global_pred,
                              final_pred & ready};
    assign out_branch_addr = pc_branch_addr + offset;

    // Update path decode
    logic                      u_local, u_global, u_final;
    logic [GHIST_BITS-1:0]     u_hist;
    logic [LOCAL_IDX_BITS-1:0] lidx_u;
    logic [GHIST_BITS-1:0]     gidx_u;
    ctr_cmd_t                  dir_cmd;

    assign u_local  = update_meta[META_LOCAL];
    assign u_global = update_meta[META_GLOBAL];
    assign u_final  = update_meta[META_FINAL];
    assign u_hist   = update_meta[META_GHIST +: GHIST_BITS];
    assign lidx_u   = lidx_of(update_pc);
    assign gidx_u   = gidx_of(update_pc, u_hist);
    assign dir_cmd  = actual_taken ? CMD_INC : CMD_DEC;

    ctr_cmd_t                  l_cmd, g_cmd, c_cmd;
    logic [LOCAL_IDX_BITS-1:0] l_widx;
    logic [GHIST_BITS-1:0]     g_widx;
    logic                      l_in_range, g_in_range;

    assign l_in_range = (init_idx_q >> LOCAL_IDX_BITS) == '0;
    assign g_in_range = (init_idx_q >> GHIST_BITS) == '0;

    always_comb begin
        l_cmd  = CMD_NONE;
        g_cmd  = CMD_NONE;
        c_cmd  = CMD_NONE;
        l_widx = lidx_u;
        g_widx = gidx_u;
        unique case (1'b1)
            init_we: begin
                l_widx = init_idx_q[LOCAL_IDX_BITS-1:0];
                g_widx = init_idx_q[GHIST_BITS-1:0];
                if (l_in_range) l_cmd = CMD_INIT;
                if (l_in_range) c_cmd = CMD_INIT;
                if (g_in_range) g_cmd = CMD_INIT;
            end
            upd_en: begin
                l_cmd = dir_cmd;
                g_cmd = dir_cmd;
                // chooser only learns when the two components disagree
                if (u_local != u_global)
                    c_cmd = (u_global == actual_taken)
                          ? CMD_INC : CMD_DEC;
            end
            default: ;
        endcase
    end

    sat_counter_table #(
        .IDX_BITS (LOCAL_IDX_BITS),
        .INIT_VAL (CTR_WEAK_TAKEN)
    ) u_local_tbl (
        .clk    (clk),
        .rd_idx (lidx_of(pc_branch_addr)),
        .rd_val (local_rd),
        .wr_cmd (l_cmd),
        .wr_idx (l_widx)
    );

    sat_counter_table #(
        .IDX_BITS (GHIST_BITS),
        .INIT_VAL (CTR_WEAK_TAKEN)
    ) u_global_tbl (
        .clk    (clk),
        .rd_idx (gidx_of(pc_branch_addr, ghist_q)),
        .rd_val (global_rd),
        .wr_cmd (g_cmd),
        .wr_idx (g_widx)
    );

    sat_counter_table #(
        .IDX_BITS (LOCAL_IDX_BITS),
        .INIT_VAL (CTR_WEAK_LOCAL)
    ) u_chooser_tbl (
        .clk    (clk),
        .rd_idx (lidx_of(pc_branch_addr)),
        .rd_val (chooser_rd),
        .wr_cmd (c_cmd),
        .wr_idx (l_widx)
    );

    // Init index, non-speculative history, perf counters
    always_ff @(posedge clk) begin
        if (reset) begin
            init_idx_q <= '0;
            ghist_q    <= '0;
            perf_b_q   <= '0;
            perf_m_q   <= '0;
        end else begin
            if (init_we)
                init_idx_q <= init_idx_q + 1'b1;
            if (upd_en) begin
                ghist_q <= {ghist_q[GHIST_BITS-2:0], actual_taken};
                if (!(&perf_b_q))
                    perf_b_q <= perf_b_q + 1'b1;
                if ((u_final != actual_taken) && !(&perf_m_q))
                    perf_m_q <= perf_m_q + 1'b1;
            end
        end
    end

    assign perf_branches    = perf_b_q;
    assign perf_mispredicts = perf_m_q;

endmodule

// File: tb/tb_tournament_predictor_param.sv
// Directed self-checking bench for tournament_predictor_param:
// init timing, predict vectors, training, same-cycle and perf cases.
module tb_tournament_predictor_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        predict_valid;
    logic [31:0] pc_branch_addr, offset, out_branch_addr;
    logic        prediction;
    logic [10:0] pred_meta;
    logic        update_valid;
    logic [31:0] update_pc;
    logic [10:0] update_meta;
    logic        actual_taken;
    logic        ready;
    logic [31:0] perf_branches, perf_mispredicts;

    logic [31:0] tgt4;
    logic        pred4, ready4;
    logic [10:0] meta4;
    logic [3:0]  pb4, pm4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tournament_predictor_param dut (
        .clk              (clk),
        .reset            (reset),
        .predict_valid    (predict_valid),
        .pc_branch_addr   (pc_branch_addr),
        .offset           (offset),
        .out_branch_addr  (out_branch_addr),
        .prediction       (prediction),
        .pred_meta        (pred_meta),
        .update_valid     (update_valid),
        .update_pc        (update_pc),
        .update_meta      (update_meta),
        .actual_taken     (actual_taken),
        .ready            (ready),
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
    );

    tournament_predictor_param #(.PERF_W(4)) dut4 (
        .clk              (clk),
        .reset            (reset),
        .predict_valid    (predict_valid),
        .pc_branch_addr   (pc_branch_addr),
        .offset           (offset),
        .out_branch_addr  (tgt4),
        .prediction       (pred4),
        .pred_meta        (meta4),
        .update_valid     (update_valid),
        .update_pc        (update_pc),
        .update_meta      (update_meta),
        .actual_taken     (actual_taken),
        .ready            (ready4),
        .perf_branches    (pb4),
        .perf_mispredicts (pm4)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] off;
        logic        pv;
        logic        exp_pred;
        logic [31:0] exp_tgt;
        logic [10:0] exp_meta;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ready && n < 400);
    endtask

    int  n;
    int  bad;
    logic p, act;
    logic [10:0] m;

    initial begin
        reset          = 1'b0;
        predict_valid  = 1'b0;
        pc_branch_addr = '0;
        offset         = '0;
        update_valid   = 1'b0;
        update_pc      = '0;
        update_meta    = '0;
        actual_taken   = 1'b0;
        #1;

        // reset state
        do_reset();
        check("rst_ready", ready, 0);
        check("rst_perf_b", perf_branches, 0);
        check("rst_perf_m", perf_mispredicts, 0);
        check("rst_perf_b4", pb4, 0);

        // target is valid while tables initialise
        pc_branch_addr = 32'h1000;
        offset         = 32'h24;
        predict_valid  = 1'b1;
        #1;
        check("init_target", out_branch_addr, 32'h1024);
        check("init_pred0", prediction, 0);
        check("init_meta_final", pred_meta[0], 0);

        // reset pulse mid-INIT restarts the sweep
        repeat (99) @(posedge clk);
        #1;
        check("init100_ready", ready, 0);
        do_reset();
        wait_ready(n);
        check("init_cycles", n, 256);
        check("post_init_perf_b", perf_branches, 0);
        check("post_init_perf_m", perf_mispredicts, 0);

        // fresh tables: everything weakly taken via local
        vecs[0] = '{32'h100, 32'h20, 1'b1, 1'b1,
                    32'h120, 11'h007};
        vecs[1] = '{32'hFFFF_FFF0, 32'h20, 1'b1, 1'b1,
                    32'h10, 11'h007};
        vecs[2] = '{32'h8, 32'hFFFF_FFFC, 1'b1, 1'b1,
                    32'h4, 11'h007};
        vecs[3] = '{32'h44, 32'h0, 1'b0, 1'b0,
                    32'h44, 11'h007};
        foreach (vecs[i]) begin
            pc_branch_addr = vecs[i].pc;
            offset         = vecs[i].off;
            predict_valid  = vecs[i].pv;
            #1;
            check($sformatf("vec%0d_pred", i),
                  prediction, vecs[i].exp_pred);
            check($sformatf("vec%0d_tgt", i),
                  out_branch_addr, vecs[i].exp_tgt);
            check($sformatf("vec%0d_meta", i),
                  pred_meta, vecs[i].exp_meta);
        end
        @(posedge clk);
        #1;

        // three not-taken updates at PC 0x4, local==global in meta
        update_valid = 1'b1;
        update_pc    = 32'h4;
        update_meta  = 11'h007;
        actual_taken = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        update_valid  = 1'b0;
        predict_valid = 1'b1;
        pc_branch_addr = 32'h4;
        #1;
        check("pc4_pred", prediction, 0);
        check("pc4_meta", pred_meta, 11'h000);
        pc_branch_addr = 32'h14;
        #1;
        check("pc14_pred", prediction, 0);
        check("pc14_meta", pred_meta, 11'h002);
        check("pc4_perf_b", perf_branches, 3);
        check("pc4_perf_m", perf_mispredicts, 3);

        // same-cycle predict/update: old value, then new value
        pc_branch_addr = 32'h20;
        update_valid   = 1'b1;
        update_pc      = 32'h20;
        update_meta    = 11'h007;
        actual_taken   = 1'b0;
        #1;
        check("same_cycle_old", prediction, 1);
        @(posedge clk);
        #1;
        update_valid = 1'b0;
        #1;
        check("same_cycle_new", prediction, 0);
        check("same_cycle_perf_b", perf_branches, 4);
        check("same_cycle_perf_m", perf_mispredicts, 4);

        // alternating T/N at PC 0x8: chooser moves to gshare
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            act            = (i % 2 == 0);
            predict_valid  = 1'b1;
            pc_branch_addr = 32'h8;
            #1;
            p = prediction;
            m = pred_meta;
            if (i >= 30 && p != act) bad++;
            update_valid = 1'b1;
            update_pc    = 32'h8;
            update_meta  = m;
            actual_taken = act;
            @(posedge clk);
            #1;
            update_valid = 1'b0;
        end
        check("alt_last10_wrong", bad, 0);
        check("alt_perf_b", perf_branches, 44);
        check("alt_perf_m", perf_mispredicts, 9);

        // updates while !ready are ignored
        do_reset();
        repeat (5) @(posedge clk);
        #1;
        update_valid = 1'b1;
        update_pc    = 32'h30;
        update_meta  = 11'h007;
        actual_taken = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        update_valid = 1'b0;
        wait_ready(n);
        check("reinit_ready", ready, 1);
        check("noupd_perf_b", perf_branches, 0);
        check("noupd_perf_m", perf_mispredicts, 0);
        pc_branch_addr = 32'h30;
        predict_valid  = 1'b1;
        #1;
        check("noupd_pred", prediction, 1);
        check("noupd_meta", pred_meta, 11'h007);

        // 20 mispredicting updates: 4-bit counters saturate
        update_valid = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        update_valid = 1'b0;
        #1;
        check("sat_perf_b4", pb4, 4'hF);
        check("sat_perf_m4", pm4, 4'hF);
        check("sat_perf_b32", perf_branches, 20);
        check("sat_perf_m32", perf_mispredicts, 20);
        check("sat_pred", prediction, 0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
